// File: rtl/dmem_ctrl_v.sv
// dmem_ctrl_v: MEM-stage data memory controller.
// Takes one load/store from the MEM stage, holds the pipeline while the
// memory request is outstanding, and returns extended load data for WB.
// Misaligned/malformed accesses are squashed with an error pulse, and
// accesses that never see an ack are abandoned after TIMEOUT wait cycles.
module dmem_ctrl_v #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_isValid,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_aluResult,
  input  logic [31:0] mem_storeData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] mem_memResult,
  output logic        access_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  // Access attributes the load-extension path needs once the ack arrives.
  typedef struct packed {
    logic [1:0] off;
    logic [2:0] f3;
  } lat_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  lat_t        lat;
  logic [7:0]  cnt;
  logic        is_rw, illegal;
  logic        wait_done, wait_tmo;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_rw     = mem_mem_read | mem_mem_write;
  assign wait_tmo  = !dmem_ack && (cnt == CNT_LAST);
  assign wait_done = dmem_ack || wait_tmo;

  // Classify the MEM-stage access as malformed or misaligned.
  always_comb begin
    illegal = 1'b0;
    if (mem_mem_read && mem_mem_write)                            illegal = 1'b1;
    if (mem_funct3 == 3'b011 || mem_funct3 == 3'b110 ||
        mem_funct3 == 3'b111)                                     illegal = 1'b1;
    if (mem_mem_write && mem_funct3[2])                           illegal = 1'b1;
    if (mem_funct3[1:0] == 2'b01 && mem_aluResult[0])             illegal = 1'b1;
    if (mem_funct3[1:0] == 2'b10 && mem_aluResult[1:0] != 2'b00)  illegal = 1'b1;
  end

  // Store lane replication and byte strobes.
  always_comb begin
    st_wdata = mem_storeData;
    st_wstrb = 4'b1111;
    case (mem_funct3[1:0])
      2'b00: begin
        st_wdata = {4{mem_storeData[7:0]}};
        st_wstrb = 4'b0001 << mem_aluResult[1:0];
      end
      2'b01: begin
        st_wdata = {2{mem_storeData[15:0]}};
        st_wstrb = mem_aluResult[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = mem_storeData;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    ld_byte = dmem_rdata[8*lat.off +: 8];
    ld_half = lat.off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat.f3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  // Next state plus the combinational pipeline handshake.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    wb_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_isValid) begin
          if (!is_rw) begin
            wb_valid = 1'b1;
          end else if (!illegal) begin
            stall     = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (wait_done) state_nxt = S_RESP;
      end
      S_RESP: begin
        wb_valid  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) begin
      stall    = 1'b0;
      wb_valid = 1'b0;
    end
  end

  // State, request latch, wait counter, result and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      lat           <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_wstrb    <= 4'h0;
      mem_memResult <= 32'h0;
      access_err    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      access_err  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_isValid && is_rw) begin
            if (illegal) begin
              access_err <= 1'b1;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_mem_write;
              dmem_addr  <= {mem_aluResult[31:2], 2'b00};
              dmem_wdata <= mem_mem_write ? st_wdata : 32'h0;
              dmem_wstrb <= mem_mem_write ? st_wstrb : 4'h0;
              lat.off    <= mem_aluResult[1:0];
              lat.f3     <= mem_funct3;
              cnt        <= 8'd0;
            end
          end
        end
        S_WAIT: begin
          if (wait_done) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            cnt           <= 8'd0;
            timeout_err   <= wait_tmo;
            mem_memResult <= (dmem_ack && !dmem_we) ? ld_ext : 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl_v.sv
// Directed bench for dmem_ctrl_v; expected access results go through a
// scoreboard queue and are popped when the controller reaches RESP.
module tb_dmem_ctrl_v;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_isValid, mem_mem_read, mem_mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_aluResult, mem_storeData;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall, wb_valid;
  logic [31:0] mem_memResult;
  logic        access_err, timeout_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic        tmo;
  } exp_t;
  exp_t sbq[$];

  dmem_ctrl_v #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .mem_isValid(mem_isValid), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_funct3(mem_funct3),
    .mem_aluResult(mem_aluResult), .mem_storeData(mem_storeData),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .wb_valid(wb_valid), .mem_memResult(mem_memResult),
    .access_err(access_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_isValid   = 1'b0;
    mem_mem_read  = 1'b0;
    mem_mem_write = 1'b0;
  endtask

  task automatic set_acc(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
    mem_isValid   = 1'b1;
    mem_mem_read  = rd;
    mem_mem_write = wr;
    mem_funct3    = f3;
    mem_aluResult = a;
    mem_storeData = sd;
  endtask

  // One legal access from IDLE through RESP back to IDLE.
  // ack_dly < 0 withholds the ack entirely.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rdat,
                        input int ack_dly, input logic [31:0] exp_res,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    exp_t e;
    int   n;
    int   exp_n;
    sbq.push_back('{res: exp_res, tmo: (ack_dly < 0)});
    exp_n = (ack_dly < 0) ? TIMEOUT : ack_dly + 1;
    dmem_rdata = rdat;
    set_acc(rd, wr, f3, a, sd);
    #1;
    chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
    chk({tag, ".idle_wb"}, 32'(wb_valid), 32'd0);
    tick();
    idle_in();
    chk({tag, ".req"}, 32'(dmem_req), 32'd1);
    chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
    chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
    if (wr) begin
      chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
      chk({tag, ".wdata"}, dmem_wdata, exp_wd);
    end
    n = 0;
    while (dmem_req === 1'b1 && n < 300) begin
      dmem_ack = (n == ack_dly);
      #1;
      if (stall !== 1'b1 || wb_valid !== 1'b0) chk({tag, ".wait_hs"}, {stall, wb_valid}, 2'b10);
      if (dmem_addr !== {a[31:2], 2'b00}) chk({tag, ".addr_hold"}, dmem_addr, {a[31:2], 2'b00});
      tick();
      dmem_ack = 1'b0;
      n++;
    end
    chk({tag, ".req_cycles"}, 32'(n), 32'(exp_n));
    #1;
    chk({tag, ".resp_req"}, 32'(dmem_req), 32'd0);
    chk({tag, ".resp_wb"}, 32'(wb_valid), 32'd1);
    chk({tag, ".resp_stall"}, 32'(stall), 32'd0);
    if (sbq.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".result"}, mem_memResult, e.res);
      chk({tag, ".tmo_err"}, 32'(timeout_err), 32'(e.tmo));
    end
    tick();
    chk({tag, ".back_idle_wb"}, 32'(wb_valid), 32'd0);
    chk({tag, ".tmo_clear"}, 32'(timeout_err), 32'd0);
  endtask

  // Malformed access: squashed with a one-cycle access_err.
  task automatic bad_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a);
    set_acc(rd, wr, f3, a, 32'h0);
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".wb"}, 32'(wb_valid), 32'd0);
    tick();
    idle_in();
    chk({tag, ".aerr"}, 32'(access_err), 32'd1);
    chk({tag, ".noreq"}, 32'(dmem_req), 32'd0);
    tick();
    chk({tag, ".aerr_clr"}, 32'(access_err), 32'd0);
    chk({tag, ".noreq2"}, 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    mem_funct3 = 3'b000;
    mem_aluResult = 32'h0;
    mem_storeData = 32'h0;
    idle_in();
    mem_isValid = 1'b1;  // handshake must stay low under reset
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.wb", 32'(wb_valid), 32'd0);
    tick();
    tick();
    idle_in();
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.addr", dmem_addr, 32'h0);
    chk("rst.wdata", dmem_wdata, 32'h0);
    chk("rst.wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst.res", mem_memResult, 32'h0);
    chk("rst.errs", {access_err, timeout_err}, 2'b00);
    reset = 1'b0;
    tick();

    // LB 0x103 -> top byte 0x80 sign-extended
    access("lb", 1, 0, 3'b000, 32'h103, 0, 32'h80FF_0000, 0, 32'hFFFF_FF80, 0, 0);

    // ADD, LHU 0x006, ADD -> wb 1,0,0,1,1
    set_acc(0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("add1.wb", 32'(wb_valid), 32'd1);
    chk("add1.stall", 32'(stall), 32'd0);
    tick();
    access("lhu", 1, 0, 3'b101, 32'h006, 0, 32'h8001_0000, 0, 32'h0000_8001, 0, 0);
    set_acc(0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("add2.wb", 32'(wb_valid), 32'd1);
    tick();
    idle_in();

    // Withheld ack: 16 wait cycles, timeout pulse, result forced to 0
    access("lw_tmo", 1, 0, 3'b010, 32'h100, 0, 32'h1234_5678, -1, 32'h0, 0, 0);

    access("lh", 1, 0, 3'b001, 32'h002, 0, 32'h8123_4567, 0, 32'hFFFF_8123, 0, 0);
    access("lbu", 1, 0, 3'b100, 32'h001, 0, 32'h0000_F100, 1, 32'h0000_00F1, 0, 0);
    access("lw", 1, 0, 3'b010, 32'h020, 0, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 0, 0);

    // Stores: result is always 0
    access("sh", 0, 1, 3'b001, 32'h202, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 32'h0, 4'b1100, 32'hBEEF_BEEF);
    access("sb", 0, 1, 3'b000, 32'h003, 32'h1234_56A5, 32'hFFFF_FFFF, 2, 32'h0, 4'b1000, 32'hA5A5_A5A5);
    access("sw", 0, 1, 3'b010, 32'h010, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 32'h0, 4'b1111, 32'hDEAD_BEEF);

    access("lb0", 1, 0, 3'b000, 32'h040, 0, 32'h0000_007F, 0, 32'h0000_007F, 0, 0);

    // Illegal accesses
    bad_access("lw_mis", 1, 0, 3'b010, 32'h101);
    bad_access("lh_mis", 1, 0, 3'b001, 32'h003);
    bad_access("sbu", 0, 1, 3'b100, 32'h000);
    bad_access("rdwr", 1, 1, 3'b010, 32'h000);
    bad_access("f3_011", 1, 0, 3'b011, 32'h000);
    chk("bad.res_kept", mem_memResult, 32'h0000_007F);

    // Stray ack in IDLE changes nothing
    dmem_rdata = 32'hFFFF_FFFF;
    dmem_ack = 1'b1;
    #1;
    chk("idle_ack.wb", 32'(wb_valid), 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("idle_ack.res", mem_memResult, 32'h0000_007F);
    chk("idle_ack.req", 32'(dmem_req), 32'd0);

    // Reset during WAIT, late ack ignored
    set_acc(1, 0, 3'b010, 32'h080, 32'h0);
    dmem_rdata = 32'h5555_AAAA;
    tick();
    idle_in();
    chk("rstw.req", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstw.stall", 32'(stall), 32'd0);
    chk("rstw.wb", 32'(wb_valid), 32'd0);
    tick();
    reset = 1'b0;
    chk("rstw.req0", 32'(dmem_req), 32'd0);
    chk("rstw.res0", mem_memResult, 32'h0);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("rstw.ack_wb", 32'(wb_valid), 32'd0);
    chk("rstw.ack_stall", 32'(stall), 32'd0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("rstw.after_wb", 32'(wb_valid), 32'd0);
    chk("rstw.after_res", mem_memResult, 32'h0);
    chk("rstw.after_req", 32'(dmem_req), 32'd0);
    chk("rstw.after_addr", dmem_addr, 32'h0);
    chk("rstw.after_errs", {access_err, timeout_err}, 2'b00);
    chk("sb.drained", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
